// File: rtl/bcd_counter_mux_if.sv
// Control and display bundle for bcd_counter_mux.
// The slave side is the counter; the master side drives count controls.
interface bcd_counter_mux_if #(
    parameter int DIGITS = 4
);
    logic                  enable;
    logic                  up_down;
    logic                  preset;
    logic [4*DIGITS-1:0]   preset_val;
    logic                  load;
    logic [4*DIGITS-1:0]   count;
    logic                  carry_out;
    logic [6:0]            ssg;
    logic [DIGITS-1:0]     an;

    modport master (
        output enable, up_down, preset, preset_val, load,
        input  count, carry_out, ssg, an
    );

    modport slave (
        input  enable, up_down, preset, preset_val, load,
        output count, carry_out, ssg, an
    );
endinterface

// File: rtl/bcd_counter_mux.sv
// Multi-digit up/down BCD counter with preset, display-hold register
// and a time-multiplexed seven-segment scan driver.
module bcd_counter_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic              clk,
    input logic              reset,
    bcd_counter_mux_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [W-1:0]      cnt;
    logic [W-1:0]      cnt_step;
    logic [W-1:0]      cnt_pre;
    logic [W-1:0]      disp;
    logic              terminal;
    logic [SW-1:0]     scan;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_n;
    logic [DIGITS-1:0] lz;
    logic [DIGITS-1:0] an_r;
    logic [6:0]        ssg_r;
    logic [3:0]        nib;
    logic [3:0]        dig_n;
    logic              zrun;
    logic              blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Ripple the step through digits; terminal survives only if every digit wrapped.
    always_comb begin
        cnt_step = cnt;
        terminal = 1'b1;
        nib      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = cnt[4*i +: 4];
            if (terminal) begin
                if (bus.up_down) begin
                    if (nib == 4'd9) begin
                        cnt_step[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_step[4*i +: 4] = nib + 4'd1;
                        terminal = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        cnt_step[4*i +: 4] = 4'd9;
                    end else begin
                        cnt_step[4*i +: 4] = nib - 4'd1;
                        terminal = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_pre = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.preset_val[4*i +: 4] > 4'd9)
                cnt_pre[4*i +: 4] = 4'd9;
            else
                cnt_pre[4*i +: 4] = bus.preset_val[4*i +: 4];
        end
    end

    // lz[i]: digits i..DIGITS-1 of the held value are all zero.
    always_comb begin
        lz   = '0;
        zrun = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun  = zrun & (disp[4*i +: 4] == 4'd0);
            lz[i] = zrun;
        end
    end

    assign idx_n = (scan != SCAN_LAST) ? idx :
                   (idx == IDX_LAST)   ? '0  : idx + 1'b1;
    assign dig_n = disp[4*idx_n +: 4];
    assign blank = BLANK_LZ && (idx_n != '0) && lz[idx_n];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            disp  <= '0;
            scan  <= '0;
            idx   <= '0;
            an_r  <= DIGITS'(1);
            ssg_r <= 7'h3F;
        end else begin
            if (bus.load)
                disp <= cnt;
            if (bus.preset)
                cnt <= cnt_pre;
            else if (bus.enable)
                cnt <= cnt_step;
            scan  <= (scan == SCAN_LAST) ? '0 : scan + 1'b1;
            idx   <= idx_n;
            // Segment data uses the pre-load display value so it matches an.
            an_r  <= DIGITS'(1) << idx_n;
            ssg_r <= blank ? 7'h00 : seg7(dig_n);
        end
    end

    assign bus.count     = cnt;
    assign bus.carry_out = bus.enable & ~reset & ~bus.preset & terminal;
    assign bus.an        = an_r;
    assign bus.ssg       = ssg_r;
endmodule

// File: tb/tb_bcd_counter_mux.sv
// Scoreboard bench for bcd_counter_mux: integer-valued reference model,
// directed scenarios followed by randomized stimulus.
module tb_bcd_counter_mux;
    localparam int D   = 4;
    localparam int SD  = 4;
    localparam bit BLZ = 1'b1;
    localparam int MOD = 10000;

    logic clk = 1'b0;
    logic reset;

    bcd_counter_mux_if #(.DIGITS(D)) bus ();

    bcd_counter_mux #(
        .DIGITS  (D),
        .SCAN_DIV(SD),
        .BLANK_LZ(BLZ)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        carry;
        logic [15:0] count;
        logic [3:0]  an;
        logic [6:0]  ssg;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    int m_cnt = 0;
    int m_disp = 0;
    int m_k = 0;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] pv);
        int s = 0;
        int n;
        for (int i = 0; i < D; i++) begin
            n = int'(pv[4*i +: 4]);
            if (n > 9) n = 9;
            s = s + n * pow10(i);
        end
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the model's expectation for it.
    task automatic cycle(input logic r, input logic en, input logic ud,
                         input logic pre, input logic [15:0] pv, input logic ld);
        exp_t e;
        int idx;
        int hi;
        @(negedge clk);
        reset          = r;
        bus.enable     = en;
        bus.up_down    = ud;
        bus.preset     = pre;
        bus.preset_val = pv;
        bus.load       = ld;
        #1;
        e.carry = en && !r && !pre && (ud ? (m_cnt == MOD - 1) : (m_cnt == 0));
        if (r) begin
            m_cnt  = 0;
            m_disp = 0;
            m_k    = 0;
            e.an   = 4'b0001;
            e.ssg  = 7'h3F;
        end else begin
            m_k++;
            idx   = (m_k / SD) % D;
            hi    = m_disp / pow10(idx);
            e.an  = 4'(1 << idx);
            e.ssg = (BLZ && idx > 0 && hi == 0) ? 7'h00 : seg_tab[hi % 10];
            if (ld) m_disp = m_cnt;
            if (pre)
                m_cnt = clamp_val(pv);
            else if (en)
                m_cnt = ud ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
        end
        e.count = to_bcd(m_cnt);
        q.push_back(e);
    endtask

    // Monitor: carry sampled mid-cycle, registered outputs just after the edge.
    initial begin
        logic c_s;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            c_s = bus.carry_out;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("carry_out", int'(c_s), int'(e.carry));
                chk("count", int'(bus.count), int'(e.count));
                chk("an", int'(bus.an), int'(e.an));
                chk("ssg", int'(bus.ssg), int'(e.ssg));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] pv;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.up_down    = 1'b1;
        bus.preset     = 1'b0;
        bus.preset_val = '0;
        bus.load       = 1'b0;

        cycle(1, 0, 1, 0, 16'h0000, 0);
        cycle(1, 1, 1, 1, 16'h1234, 1);
        repeat (18) cycle(0, 0, 1, 0, 16'h0000, 0);

        cycle(0, 0, 1, 1, 16'h0998, 0);
        repeat (3) cycle(0, 1, 1, 0, 16'h0000, 0);
        cycle(0, 1, 1, 1, 16'h9999, 0);
        cycle(0, 1, 1, 0, 16'h0000, 0);
        cycle(0, 0, 1, 0, 16'h0000, 0);

        cycle(0, 1, 0, 1, 16'h0001, 0);
        repeat (2) cycle(0, 1, 0, 0, 16'h0000, 0);
        cycle(0, 0, 0, 0, 16'h0000, 0);

        cycle(0, 0, 1, 1, 16'hF3A1, 0);
        cycle(0, 0, 1, 0, 16'h0000, 0);

        cycle(0, 0, 1, 1, 16'h0042, 0);
        cycle(0, 1, 1, 0, 16'h0000, 1);
        repeat (18) cycle(0, 0, 1, 0, 16'h0000, 0);

        cycle(1, 0, 1, 0, 16'h0000, 0);
        repeat (11) cycle(0, 1, 1, 0, 16'h0000, 1);
        cycle(1, 1, 1, 1, 16'h5555, 1);
        repeat (6) cycle(0, 0, 1, 0, 16'h0000, 0);

        repeat (3000) begin
            case ($urandom_range(0, 3))
                0:       pv = 16'h9999;
                1:       pv = 16'h0000;
                2:       pv = 16'h0001;
                default: pv = 16'($urandom);
            endcase
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  ($urandom_range(0, 15) == 0),
                  pv,
                  ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
